// File: rtl/sad_best_match.sv
// sad_best_match: collects N_CAND SAD results from the SAD stage over a
// four-phase done/ack handshake and keeps the running minimum and its index.
// The best match is then presented until result_ack takes it.
//
// Handshake semantics:
//   SAD side (four-phase): the producer raises sad_done with sad_in stable.
//   sad_ack rises one clk after sad_done is sampled high. The producer then
//   drops sad_done, and sad_ack falls one clk after sad_done is sampled low.
//   Each done/ack cycle captures exactly one result.
//   Result side (valid/ack): result_valid stays high with best_sad/best_idx
//   frozen until result_ack is sampled high. The transfer happens on that
//   edge, and result_valid drops on the same edge.
module sad_best_match #(
  parameter int WIDTH  = 8,
  parameter int SAD_W  = WIDTH + 5,
  parameter int N_CAND = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad_in,
  output logic             sad_ack,
  input  logic             result_ack,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             result_valid,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESULT  = 2'd3;

  // Terminal count: cnt stops at N_CAND-1 and never wraps.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] cnt;

  // The first candidate always loads. Later candidates load only when they
  // are strictly smaller, so the earliest minimum wins a tie.
  logic take_new;
  assign take_new = (cnt == '0) || (sad_in < best_sad);

  // Search FSM with registered handshake outputs and the best-match tracker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      best_sad     <= '1;
      best_idx     <= '0;
      sad_ack      <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_WAIT;
            cnt      <= '0;
            best_sad <= '1;
            best_idx <= '0;
            busy     <= 1'b1;
          end
        end
        S_WAIT: begin
          if (sad_done) begin
            state   <= S_CAPTURE;
            sad_ack <= 1'b1;
            if (take_new) begin
              best_sad <= sad_in;
              best_idx <= cnt;
            end
          end
        end
        S_CAPTURE: begin
          // sad_done held high keeps the FSM here, so a result is never
          // captured twice.
          if (!sad_done) begin
            sad_ack <= 1'b0;
            if (cnt == LAST_IDX) begin
              state        <= S_RESULT;
              result_valid <= 1'b1;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_WAIT;
            end
          end
        end
        S_RESULT: begin
          if (result_ack) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_sad_best_match.sv
// Testbench for sad_best_match: table-driven searches with hand-computed
// answers, randomized searches checked against a min/argmin reference,
// and directed sequences for reset, handshake hold and result hold.
module tb_sad_best_match;

  localparam int WIDTH  = 8;
  localparam int SAD_W  = 13;
  localparam int N_CAND = 16;
  localparam int IDX_W  = 4;

  typedef logic [N_CAND-1:0][SAD_W-1:0] sad_vec_t;

  typedef struct {
    string            name;
    sad_vec_t         sads;
    logic [SAD_W-1:0] exp_sad;
    logic [IDX_W-1:0] exp_idx;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sad_done;
  logic [SAD_W-1:0] sad_in;
  logic             sad_ack;
  logic             result_ack;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;
  logic             result_valid;
  logic             busy;
  logic [1:0]       dbg_state;

  int errors = 0;
  int checks = 0;

  logic [SAD_W+IDX_W-1:0] exp_q[$];

  sad_best_match #(
    .WIDTH (WIDTH),
    .SAD_W (SAD_W),
    .N_CAND(N_CAND),
    .IDX_W (IDX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sad_done    (sad_done),
    .sad_in      (sad_in),
    .sad_ack     (sad_ack),
    .result_ack  (result_ack),
    .best_sad    (best_sad),
    .best_idx    (best_idx),
    .result_valid(result_valid),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: smallest SAD, earliest index on ties
  task automatic ref_best(input sad_vec_t s, output logic [SAD_W-1:0] bs,
                          output logic [IDX_W-1:0] bi);
    bs = s[0];
    bi = '0;
    for (int i = 1; i < N_CAND; i++) begin
      if (s[i] < bs) begin
        bs = s[i];
        bi = IDX_W'(i);
      end
    end
  endtask

  // Driver: one four-phase transfer; called and returns at a negedge
  task automatic send_sad(input logic [SAD_W-1:0] v, input int extra);
    int n;
    sad_in   = v;
    sad_done = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sad_ack && n < 20);
    check("ack_rise_latency", 32'(n), 32'd1);
    for (int k = 0; k < extra; k++) begin
      @(negedge clk);
      check("ack_hold_high", 32'(sad_ack), 32'd1);
    end
    sad_done = 1'b0;
    sad_in   = SAD_W'($urandom_range(0, 8191));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sad_ack && n < 20);
    check("ack_fall_latency", 32'(n), 32'd1);
  endtask

  // Driver: complete search, ending in RESULT with outputs compared
  task automatic run_search(input sad_vec_t s, input int hold_cand, input int hold_extra,
                            input string name);
    logic [SAD_W+IDX_W-1:0] exp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < N_CAND; i++) begin
      // start and result_ack mid-search must be ignored
      if (i == 5) begin
        start      = 1'b1;
        result_ack = 1'b1;
      end
      send_sad(s[i], (i == hold_cand) ? hold_extra : 0);
      start      = 1'b0;
      result_ack = 1'b0;
      if (i < N_CAND - 1) check({name, "_no_early_valid"}, 32'(result_valid), 32'd0);
    end
    check({name, "_result_valid"}, 32'(result_valid), 32'd1);
    check({name, "_queue_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({name, "_best_sad"}, 32'(best_sad), 32'(exp[SAD_W+IDX_W-1:IDX_W]));
      check({name, "_best_idx"}, 32'(best_idx), 32'(exp[IDX_W-1:0]));
    end
  endtask

  task automatic finish_search(input string name);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    check({name, "_valid_cleared"}, 32'(result_valid), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  vec_t             vecs[3];
  sad_vec_t         rs;
  logic [SAD_W-1:0] es;
  logic [IDX_W-1:0] ei;

  initial begin
    // Table: descending sweep, tie, extremes
    vecs[0].name = "sweep";
    for (int i = 0; i < N_CAND; i++) vecs[0].sads[i] = SAD_W'(100 - i);
    vecs[0].exp_sad = 13'd85;
    vecs[0].exp_idx = 4'd15;
    vecs[1].name = "tie";
    vecs[1].sads[0] = 13'd50;
    vecs[1].sads[1] = 13'd20;
    vecs[1].sads[2] = 13'd20;
    for (int i = 3; i < N_CAND - 1; i++) vecs[1].sads[i] = SAD_W'(70 + i);
    vecs[1].sads[N_CAND-1] = 13'd90;
    vecs[1].exp_sad = 13'd20;
    vecs[1].exp_idx = 4'd1;
    vecs[2].name = "extremes";
    for (int i = 0; i < N_CAND; i++) vecs[2].sads[i] = 13'h1FFF;
    vecs[2].sads[9] = 13'd0;
    vecs[2].exp_sad = 13'd0;
    vecs[2].exp_idx = 4'd9;

    rst        = 1'b1;
    start      = 1'b0;
    sad_done   = 1'b0;
    sad_in     = '0;
    result_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_best_sad", 32'(best_sad), 32'h1FFF);
    check("reset_best_idx", 32'(best_idx), 32'd0);
    check("reset_sad_ack", 32'(sad_ack), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // sad_done and result_ack in IDLE are ignored
    sad_done   = 1'b1;
    result_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_done_no_ack", 32'(sad_ack), 32'd0);
      check("idle_stays_idle", 32'(busy), 32'd0);
    end
    sad_done   = 1'b0;
    result_ack = 1'b0;

    for (int v = 0; v < 3; v++) begin
      exp_q.push_back({vecs[v].exp_sad, vecs[v].exp_idx});
      run_search(vecs[v].sads, -1, 0, vecs[v].name);
      if (v == 0) begin
        // Result hold with stray start pulses
        for (int k = 0; k < 10; k++) begin
          start = k[0];
          @(negedge clk);
          check("hold_valid", 32'(result_valid), 32'd1);
          check("hold_best_sad", 32'(best_sad), 32'd85);
          check("hold_best_idx", 32'(best_idx), 32'd15);
        end
        // start together with result_ack: return to IDLE, no restart
        start      = 1'b1;
        result_ack = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        result_ack = 1'b0;
        check("ack_start_valid", 32'(result_valid), 32'd0);
        check("ack_start_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("ack_start_no_restart", 32'(busy), 32'd0);
      end else begin
        finish_search(vecs[v].name);
      end
    end

    // Long sad_done hold on candidate 7: one capture only
    for (int i = 0; i < N_CAND; i++) rs[i] = SAD_W'($urandom_range(0, 8191));
    ref_best(rs, es, ei);
    exp_q.push_back({es, ei});
    run_search(rs, 7, 5, "done_hold");
    finish_search("done_hold");

    // Randomized searches, alternating narrow (tie-heavy) and full range
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_CAND; i++)
        rs[i] = r[0] ? SAD_W'($urandom_range(0, 7)) : SAD_W'($urandom_range(0, 8191));
      ref_best(rs, es, ei);
      exp_q.push_back({es, ei});
      run_search(rs, $urandom_range(0, N_CAND - 1), $urandom_range(0, 2), "random");
      finish_search("random");
    end

    // Asynchronous reset in the middle of CAPTURE
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_sad(13'd3, 0);
    sad_in   = 13'd1;
    sad_done = 1'b1;
    @(negedge clk);
    check("pre_reset_ack", 32'(sad_ack), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ack", 32'(sad_ack), 32'd0);
    check("async_rst_valid", 32'(result_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_best_sad", 32'(best_sad), 32'h1FFF);
    check("async_rst_best_idx", 32'(best_idx), 32'd0);
    @(negedge clk);
    sad_done = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);

    // Fresh search after the abandoned one
    for (int i = 0; i < N_CAND; i++) rs[i] = SAD_W'($urandom_range(0, 8191));
    ref_best(rs, es, ei);
    exp_q.push_back({es, ei});
    run_search(rs, -1, 0, "after_reset");
    finish_search("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
